shreg_seq_ctrl: RTL and testbench
=================================

Name: shreg_seq_ctrl

Overview:
- Command sequencer for a 4-bit universal shift register with ports clk, sel[1:0] and I[3:0] and output A.
- Accepts a "load value then shift N places left/right" command over a start/busy/done handshake.
- Drives the register's sel and I so a single requester never has to time sel codes itself.
- Sits between control logic and the shift register; outputs connect directly to sel/I of the register instance.

Parameters:
- WIDTH, 4, data width of I and data_in
- CNT_W, 3, width of shift-count field; max shift amount 2**CNT_W-1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  command request; sampled only where stated below
- dir  input  1  0 = shift right (sel 01), 1 = shift left (sel 10)
- amount  input  CNT_W  number of shift cycles after load
- data_in  input  WIDTH  value to parallel-load
- sel  output  2  to register: 00 hold, 01 shift right, 10 shift left, 11 parallel load
- I  output  WIDTH  to register parallel input
- busy  output  1  command in progress (LOAD or SHIFT)
- done  output  1  one-cycle completion pulse
- pend  output  1  pending-command flag (optional feature; constant 0 when compiled out)

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (any time, including mid-command):
  - state=IDLE; sel=00, I=0, busy=0, done=0, pend=0.
  - captured command registers and shift counter cleared.
- Moore machine: sel, I, busy and done are decoded from registered state and captured registers only. No combinational path from start/data_in to outputs.
- States:
  - IDLE: sel=00, I=0. If start=1 at clk edge, capture data_in/dir/amount and go to LOAD.
  - LOAD: sel=11, I=captured data, busy=1. Lasts exactly 1 cycle. Counter := amount. Next state is SHIFT if amount!=0, else DONE.
  - SHIFT: sel = dir ? 10 : 01, I=captured data (don't-care to register), busy=1. Counter decrements each cycle; when counter==1 at edge, go to DONE. Exactly `amount` SHIFT cycles.
  - DONE: sel=00, done=1, busy=0, I=0. Lasts 1 cycle, then IDLE, or LOAD if pending (see Optional Feature).
- Latency: start sampled at edge k -> LOAD visible in cycle k+1 -> done high in cycle k+2+amount. Back to IDLE at k+3+amount.
- start in LOAD/SHIFT/DONE is ignored (feature off). Inputs are not required to be held after acceptance.
- amount=0 yields load-only: LOAD, then DONE.
- amount values greater than WIDTH are executed literally (register shifts out fully). No saturation.
- busy and done are never both 1.

Optional Feature:
- Macro: SHREG_SEQ_QUEUE_EN.
- Defined: one-deep pending-command buffer.
  - start=1 while state is LOAD, SHIFT or DONE with pend=0 captures data_in/dir/amount into the buffer and sets pend=1.
  - start while pend=1 is ignored (buffer not overwritten).
  - On leaving DONE with pend=1: go directly to LOAD with the buffered command and clear pend. The IDLE cycle is skipped.
  - If start arrives in the same DONE cycle that would set pend, the buffer is used and LOAD follows immediately.
  - rst clears the buffer.
- Undefined: no buffer; pend tied 0; behaviour exactly as above.

Test Plan:
- Reset mid-SHIFT: rst=1 during command data_in=1010, dir=1, amount=3 -> sel=00, busy=0, done=0, I=0 immediately (asynchronously), before next edge.
- Load+shift left: start, data_in=1010, dir=1, amount=2 -> sel sequence 11,10,10,00 on consecutive cycles; done pulses only in the 00 cycle; register model A: 1010 -> 0100 -> 1000.
- Load+shift right: data_in=0011, dir=0, amount=1 -> sel 11,01,00; done 1 cycle; A=0011 -> 0001 (0 fill).
- Load only: data_in=1100, amount=0 -> sel 11 then 00 with done=1; A=1100; busy high exactly 1 cycle.
- Ignored start: second start (data_in=1111) during SHIFT of amount=3 command -> no effect without macro; with SHREG_SEQ_QUEUE_EN, pend=1, and LOAD with I=1111 follows DONE directly.
- Max count: amount=7, dir=1, data_in=1111 -> 7 cycles of sel=10, then done; A=0000; busy high 8 cycles.

Source files
------------

// File: rtl/shreg_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shreg_seq_ctrl
// Description : Command sequencer for a 4-bit universal shift register.
//               It accepts a "load value, then shift N places left/right"
//               command over a start/busy/done handshake. It drives the
//               register's sel/I pins, so the requester never has to time
//               sel codes itself.
//
// Ports       : clk      rising-edge clock
//               rst      asynchronous, active-high reset
//               start    command request (sampled in IDLE; with the queue
//                        enabled, also while a command is running)
//               dir      0 = shift right (sel 01), 1 = shift left (sel 10)
//               amount   number of shift cycles after the load
//               data_in  value to parallel-load
//               sel      to register: 00 hold, 01 shr, 10 shl, 11 load
//               I        to register parallel input
//               busy     command in progress (LOAD or SHIFT)
//               done     one-cycle completion pulse
//               pend     pending-command flag (0 when the queue is absent)
//
// Options     : SHREG_SEQ_QUEUE_EN - adds a one-deep pending-command buffer
//               that chains the next command straight from DONE into LOAD.
//
// Revision    : 1.0 - initial release
// ============================================================================
module shreg_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] I,
    output logic             busy,
    output logic             done,
    output logic             pend
);

    localparam logic [1:0] C_SEL_HOLD = 2'b00;
    localparam logic [1:0] C_SEL_SHR  = 2'b01;
    localparam logic [1:0] C_SEL_SHL  = 2'b10;
    localparam logic [1:0] C_SEL_LOAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_data;
    logic               r_dir;
    logic [CNT_W-1:0]   r_amount;
    logic [CNT_W-1:0]   r_cnt;

    // Outputs are registered copies of the decode for the *next* state, so
    // nothing from start/data_in reaches the pins combinationally.
    logic [1:0]         r_sel;
    logic [WIDTH-1:0]   r_i;
    logic               r_busy;
    logic               r_done;

`ifdef SHREG_SEQ_QUEUE_EN
    logic [WIDTH-1:0]   r_q_data;
    logic               r_q_dir;
    logic [CNT_W-1:0]   r_q_amount;
    logic               r_pend;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_dir      <= 1'b0;
            r_amount   <= '0;
            r_cnt      <= '0;
            r_sel      <= C_SEL_HOLD;
            r_i        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef SHREG_SEQ_QUEUE_EN
            r_q_data   <= '0;
            r_q_dir    <= 1'b0;
            r_q_amount <= '0;
            r_pend     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_data   <= data_in;
                        r_dir    <= dir;
                        r_amount <= amount;
                        r_state  <= S_LOAD;
                        r_sel    <= C_SEL_LOAD;
                        r_i      <= data_in;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                    end
                end

                S_LOAD: begin
                    r_cnt <= r_amount;
                    if (r_amount != '0) begin
                        r_state <= S_SHIFT;
                        r_sel   <= r_dir ? C_SEL_SHL : C_SEL_SHR;
                        r_i     <= r_data;
                    end else begin
                        // Load-only command: skip SHIFT entirely.
                        r_state <= S_DONE;
                        r_sel   <= C_SEL_HOLD;
                        r_i     <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    r_cnt <= r_cnt - 1'b1;
                    // The counter holds the number of shift cycles still to
                    // go, including the current one, so 1 means last.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_sel   <= C_SEL_HOLD;
                        r_i     <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                S_DONE: begin
                    r_done <= 1'b0;
`ifdef SHREG_SEQ_QUEUE_EN
                    if (r_pend) begin
                        // Chain the buffered command without an IDLE gap.
                        r_data   <= r_q_data;
                        r_dir    <= r_q_dir;
                        r_amount <= r_q_amount;
                        r_pend   <= 1'b0;
                        r_state  <= S_LOAD;
                        r_sel    <= C_SEL_LOAD;
                        r_i      <= r_q_data;
                        r_busy   <= 1'b1;
                    end else if (start) begin
                        // A request in DONE would fill the buffer and drain
                        // it on the same edge, so it is taken directly.
                        r_data   <= data_in;
                        r_dir    <= dir;
                        r_amount <= amount;
                        r_state  <= S_LOAD;
                        r_sel    <= C_SEL_LOAD;
                        r_i      <= data_in;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state  <= S_IDLE;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end

                default: begin
                    r_state <= S_IDLE;
                    r_sel   <= C_SEL_HOLD;
                    r_i     <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase

`ifdef SHREG_SEQ_QUEUE_EN
            // Buffer a request that arrives while a command is running.
            // A request arriving while the buffer is full is dropped.
            if ((r_state == S_LOAD || r_state == S_SHIFT) && start && !r_pend) begin
                r_q_data   <= data_in;
                r_q_dir    <= dir;
                r_q_amount <= amount;
                r_pend     <= 1'b1;
            end
`endif
        end
    end

    assign sel  = r_sel;
    assign I    = r_i;
    assign busy = r_busy;
    assign done = r_done;

`ifdef SHREG_SEQ_QUEUE_EN
    assign pend = r_pend;
`else
    assign pend = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shreg_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shreg_seq_ctrl
// Description : Self-checking bench for shreg_seq_ctrl. It runs directed and
//               randomized commands against a cycle-indexed reference model.
//               A behavioural 4-bit universal shift register is driven from
//               the DUT's sel/I pins, and the bench checks the final value
//               in that register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shreg_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int OBS_W = WIDTH + 5;   // {sel, I, busy, done, pend}

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] data_in;
    logic [1:0]       sel;
    logic [WIDTH-1:0] I;
    logic             busy;
    logic             done;
    logic             pend;

    logic [WIDTH-1:0] A;                // modelled shift-register contents
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shreg_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dir     (dir),
        .amount  (amount),
        .data_in (data_in),
        .sel     (sel),
        .I       (I),
        .busy    (busy),
        .done    (done),
        .pend    (pend)
    );

    // Behavioural universal shift register, driven by the DUT's sel and I.
    always @(posedge clk or posedge rst) begin
        if (rst) A <= '0;
        else begin
            case (sel)
                2'b01:   A <= {1'b0, A[WIDTH-1:1]};
                2'b10:   A <= {A[WIDTH-2:0], 1'b0};
                2'b11:   A <= I;
                default: A <= A;
            endcase
        end
    end

    // Expected pins in cycle n after a command is accepted. Cycle 0 is the
    // load, cycles 1..amt shift, amt+1 completes, and later cycles are idle.
    function automatic logic [OBS_W-1:0] exp_at(input int n, input logic [WIDTH-1:0] d,
                                                input logic dr, input int amt);
        if (n == 0)            return {2'b11, d, 1'b1, 1'b0, 1'b0};
        else if (n <= amt)     return {(dr ? 2'b10 : 2'b01), d, 1'b1, 1'b0, 1'b0};
        else if (n == amt + 1) return {2'b00, {WIDTH{1'b0}}, 1'b0, 1'b1, 1'b0};
        else                   return {2'b00, {WIDTH{1'b0}}, 1'b0, 1'b0, 1'b0};
    endfunction

    function automatic logic [WIDTH-1:0] exp_final(input logic [WIDTH-1:0] d,
                                                   input logic dr, input int amt);
        logic [31:0] t;
        t = dr ? ({28'b0, d} << amt) : ({28'b0, d} >> amt);
        return t[WIDTH-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge, then scramble the inputs. The DUT
    // must not depend on the inputs once the command is accepted.
    task automatic issue(input logic [WIDTH-1:0] d, input logic dr, input int amt);
        start   = 1'b1;
        data_in = d;
        dir     = dr;
        amount  = CNT_W'(amt);
        tick();
        start   = 1'b0;
        data_in = WIDTH'($urandom);
        dir     = 1'($urandom);
        amount  = CNT_W'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dir = 1'b0; amount = '0; data_in = '0;
        tick();
        tick();
        checks++;
        if ({sel, I, busy, done, pend} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", {sel, I, busy, done, pend}, {OBS_W{1'b0}});
        end
        #2 rst = 1'b0;
        tick();
        checks++;
        if ({sel, I, busy, done, pend} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected %b", {sel, I, busy, done, pend}, {OBS_W{1'b0}});
        end
    endtask

    task automatic test_reset_mid_shift();
        issue(4'b1010, 1'b1, 3);
        tick();                     // first SHIFT cycle
        checks++;
        if (sel !== 2'b10) begin
            errors++;
            $display("FAIL mid_shift_sel: got %b expected 10", sel);
        end
        #2 rst = 1'b1;
        #1;                         // still well before the next edge
        checks++;
        if ({sel, I, busy, done, pend} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", {sel, I, busy, done, pend}, {OBS_W{1'b0}});
        end
        tick();
        #2 rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if ({sel, I, busy, done, pend} !== '0) begin
                errors++;
                $display("FAIL post_reset_idle: cycle %0d got %b expected %b", n,
                         {sel, I, busy, done, pend}, {OBS_W{1'b0}});
            end
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] td [4] = '{4'b1010, 4'b0011, 4'b1100, 4'b1111};
        logic             tr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int               ta [4] = '{2, 1, 0, 7};
        logic [OBS_W-1:0] e;
        int busy_cnt, done_cnt;
        for (int k = 0; k < 4; k++) begin
            busy_cnt = 0;
            done_cnt = 0;
            issue(td[k], tr[k], ta[k]);
            for (int n = 0; n <= ta[k] + 2; n++) begin
                e = exp_at(n, td[k], tr[k], ta[k]);
                busy_cnt += int'(busy);
                done_cnt += int'(done);
                checks++;
                if ({sel, I, busy, done, pend} !== e) begin
                    errors++;
                    $display("FAIL directed%0d_cycle%0d: got %b expected %b", k, n,
                             {sel, I, busy, done, pend}, e);
                end
                if (n != ta[k] + 2) tick();
            end
            checks++;
            if (A !== exp_final(td[k], tr[k], ta[k])) begin
                errors++;
                $display("FAIL directed%0d_A: got %b expected %b", k, A, exp_final(td[k], tr[k], ta[k]));
            end
            checks++;
            if (busy_cnt != ta[k] + 1 || done_cnt != 1) begin
                errors++;
                $display("FAIL directed%0d_pulses: busy %0d done %0d expected busy %0d done 1",
                         k, busy_cnt, done_cnt, ta[k] + 1);
            end
            tick();
        end
    endtask

    task automatic test_ignored_start();
        logic [OBS_W-1:0] e;
        issue(4'b0110, 1'b0, 3);
        for (int n = 0; n <= 7; n++) begin
            e = exp_at(n, 4'b0110, 1'b0, 3);
`ifdef SHREG_SEQ_QUEUE_EN
            if (n == 3 || n == 4) e[0] = 1'b1;
            if (n == 5) e = {2'b11, 4'b1111, 1'b1, 1'b0, 1'b0};
            if (n == 6) e = {2'b00, 4'b0000, 1'b0, 1'b1, 1'b0};
`endif
            checks++;
            if ({sel, I, busy, done, pend} !== e) begin
                errors++;
                $display("FAIL ignored_start_cycle%0d: got %b expected %b", n,
                         {sel, I, busy, done, pend}, e);
            end
            // A second request in SHIFT, then another that must not overwrite it.
            start   = (n == 2 || n == 3);
            data_in = (n == 2) ? 4'b1111 : 4'b0000;
            dir     = 1'b1;
            amount  = '0;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] d;
        logic             dr;
        int               amt, gap, mid;
        logic [OBS_W-1:0] e;
        for (int k = 0; k < 30; k++) begin
            d   = WIDTH'($urandom);
            dr  = 1'($urandom);
            amt = int'($urandom_range(0, 7));
            gap = int'($urandom_range(0, 2));
            mid = int'($urandom_range(1, amt + 1));
            for (int g = 0; g < gap; g++) tick();
            issue(d, dr, amt);
            for (int n = 0; n <= amt + 2; n++) begin
                e = exp_at(n, d, dr, amt);
                checks++;
                if ({sel, I, busy, done, pend} !== e) begin
                    errors++;
                    $display("FAIL random%0d_cycle%0d: got %b expected %b", k, n,
                             {sel, I, busy, done, pend}, e);
                end
                checks++;
                if (busy && done) begin
                    errors++;
                    $display("FAIL random%0d_busy_done: got both 1 expected exclusive", k);
                end
`ifndef SHREG_SEQ_QUEUE_EN
                start = (n == mid);     // stray request must be ignored
`endif
                if (n != amt + 2) tick();
                start = 1'b0;
            end
            checks++;
            if (A !== exp_final(d, dr, amt)) begin
                errors++;
                $display("FAIL random%0d_A: got %b expected %b", k, A, exp_final(d, dr, amt));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        tick();
        test_reset_mid_shift();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
